// File: rtl/mem_pipelined.sv
// rtl/mem_pipelined.sv - pipelined 1R1W scratchpad with byte enables, read-during-write control and post-reset clear
module mem_pipelined #(
    parameter int NUM_ENTRIES    = 64,
    parameter int WORD_SIZE      = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ADDR_WIDTH     = $clog2(NUM_ENTRIES),
    parameter int NUM_BYTES      = WORD_SIZE / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [WORD_SIZE-1:0]  r_data,
    output logic                  r_valid,
    output logic                  r_err,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [WORD_SIZE-1:0]  w_data,
    input  logic [NUM_BYTES-1:0]  w_be,
    output logic                  w_err
);
    localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(NUM_ENTRIES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic [WORD_SIZE-1:0]  mem [NUM_ENTRIES];

    logic                  rd_acc;
    logic                  rd_oob;
    logic                  wr_acc;
    logic                  wr_oob;
    logic                  wr_hit;
    logic [WORD_SIZE-1:0]  rd_word;

    logic [READ_LATENCY-1:0] pipe_v;
    logic [READ_LATENCY-1:0] pipe_e;
    logic [WORD_SIZE-1:0]    pipe_d [READ_LATENCY];

    assign rd_oob = {1'b0, r_addr} >= DEPTH;
    assign wr_oob = {1'b0, w_addr} >= DEPTH;
    assign rd_acc = ready && r_en;
    // A write with no lanes enabled is a no-op, so it never counts as accepted.
    assign wr_acc = ready && w_en && (|w_be) && !wr_oob;
    assign wr_hit = wr_acc && (w_addr == r_addr);

    always_comb begin
        rd_word = '0;
        if (!rd_oob) begin
            rd_word = mem[r_addr];
            if (RDW_MODE == 1 && wr_hit) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (w_be[i]) begin
                        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            ready     <= 1'b0;
            clear_cnt <= '0;
            w_err     <= 1'b0;
        end else begin
            w_err <= ready && w_en && (|w_be) && wr_oob;
            case (state)
                ST_INIT: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == LAST_ADDR) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    // Storage has no reset of its own; it is only zeroed by the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[clear_cnt] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (w_be[i]) begin
                        mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Data stages only advance behind a valid, so the output stage holds the last returned word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
            pipe_e <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_acc;
            pipe_e[0] <= rd_acc && rd_oob;
            if (rd_acc) begin
                pipe_d[0] <= rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                if (pipe_v[i-1]) begin
                    pipe_d[i] <= pipe_d[i-1];
                end
            end
        end
    end

    assign r_valid = pipe_v[READ_LATENCY-1];
    assign r_err   = pipe_e[READ_LATENCY-1];
    assign r_data  = pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_pipelined.sv
// tb/tb_mem_pipelined.sv - randomized scoreboard bench over several mem_pipelined configurations
module tb_mem_pipelined;
    localparam int NI = 4;

    typedef struct packed {
        int          stamp;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_en = 1'b0;
    logic [2:0]  r_addr = '0;
    logic        w_en = 1'b0;
    logic [2:0]  w_addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_be = '0;

    logic [NI:0] ready;
    logic [NI:0] r_valid;
    logic [NI:0] r_err;
    logic [NI:0] w_err;
    logic [31:0] r_data [NI+1];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    logic [31:0] mdl_mem [NI][8];
    rsp_t        exp_q [NI][$];
    rsp_t        obs_q [NI][$];
    int          obs_rd [NI];
    int          exp_werr [NI];
    int          werr_cnt [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g <= NI; g++) begin : g_dut
        mem_pipelined #(
            .NUM_ENTRIES   ((g % 2 == 0) ? 8 : 6),
            .WORD_SIZE     (32),
            .BYTE_WIDTH    (8),
            .READ_LATENCY  ((g == NI) ? 1 : g + 1),
            .RDW_MODE      (g % 2),
            .CLEAR_ON_RESET((g == NI) ? 0 : 1)
        ) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .ready  (ready[g]),
            .r_en   (r_en),
            .r_addr (r_addr),
            .r_data (r_data[g]),
            .r_valid(r_valid[g]),
            .r_err  (r_err[g]),
            .w_en   (w_en),
            .w_addr (w_addr),
            .w_data (w_data),
            .w_be   (w_be),
            .w_err  (w_err[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (r_valid[i]) obs_q[i].push_back({cyc, r_err[i], r_data[i]});
            if (w_err[i]) werr_cnt[i]++;
        end
    end

    function automatic int ne(input int i);
        return (i % 2 == 0) ? 8 : 6;
    endfunction

    function automatic int lat(input int i);
        return i + 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (be[b]) res[b*8 +: 8] = nw[b*8 +: 8];
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++) for (int a = 0; a < 8; a++) mdl_mem[i][a] = '0;
    endtask

    task automatic drive_cycle(input logic re, input logic [2:0] ra, input logic we,
                               input logic [2:0] wa, input logic [31:0] wd, input logic [3:0] wbe);
        r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd; w_be = wbe;
        for (int i = 0; i < NI; i++) begin
            if (re) begin
                rsp_t e;
                e.stamp = cyc + lat(i);
                if (int'(ra) >= ne(i)) begin
                    e.err = 1'b1;
                    e.data = '0;
                end else begin
                    e.err = 1'b0;
                    e.data = mdl_mem[i][ra];
                    if (i % 2 == 1 && we && wa == ra) e.data = merge(e.data, wd, wbe);
                end
                exp_q[i].push_back(e);
            end
            if (we && wbe != 4'h0) begin
                if (int'(wa) < ne(i)) mdl_mem[i][wa] = merge(mdl_mem[i][wa], wd, wbe);
                else exp_werr[i]++;
            end
        end
        step();
        r_en = 1'b0; w_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i <= NI; i++) begin
            checks++;
            if ({ready[i], r_valid[i], r_err[i], w_err[i]} !== 4'b0 || r_data[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs[%0d] got rdy/val/rerr/werr=%b%b%b%b data=%h exp=0000 data=0",
                         i, ready[i], r_valid[i], r_err[i], w_err[i], r_data[i]);
            end
        end
        model_clear();
        rst_n = 1'b1;
        r_en = 1'b1; r_addr = 3'd2; w_en = 1'b1; w_addr = 3'd2; w_data = 32'hDEAD_BEEF; w_be = 4'hF;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (n == 6) begin r_en = 1'b0; w_en = 1'b0; end
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (ready[i] !== (n >= ne(i))) begin
                    failures++;
                    $display("FAIL init_ready[%0d] n=%0d got=%b exp=%b", i, n, ready[i], n >= ne(i));
                end
            end
            checks++;
            if (ready[NI] !== 1'b1) begin
                failures++;
                $display("FAIL noclear_ready n=%0d got=%b exp=1", n, ready[NI]);
            end
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_q[i].size() != 0) begin
                failures++;
                $display("FAIL init_no_rvalid[%0d] got=%0d strobes exp=0", i, obs_q[i].size());
            end
        end
    endtask

    task automatic test_clear();
        for (int a = 0; a < 8; a++) drive_cycle(1'b1, 3'(a), 1'b0, 3'd0, 32'h0, 4'h0);
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_q[i].size() - obs_rd[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL clear_count[%0d] got=%0d exp=%0d", i, obs_q[i].size() - obs_rd[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL clear_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    task automatic test_latency();
        for (int a = 0; a < 8; a++) drive_cycle(1'b0, 3'd0, 1'b1, 3'(a), 32'hA5A5_0000 + 32'(a), 4'hF);
        for (int a = 0; a < 8; a++) drive_cycle(1'b1, 3'(a), 1'b0, 3'd0, 32'h0, 4'h0);
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_q[i].size() - obs_rd[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL latency_count[%0d] got=%0d exp=%0d", i, obs_q[i].size() - obs_rd[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL latency_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    task automatic test_byte_enable();
        drive_cycle(1'b0, 3'd0, 1'b1, 3'd2, 32'h1122_3344, 4'b1111);
        drive_cycle(1'b0, 3'd0, 1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101);
        drive_cycle(1'b1, 3'd2, 1'b0, 3'd0, 32'h0, 4'h0);
        drive_cycle(1'b0, 3'd0, 1'b1, 3'd2, $urandom, 4'b0000);
        drive_cycle(1'b1, 3'd2, 1'b0, 3'd0, 32'h0, 4'h0);
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (mdl_mem[i][2] !== 32'h11BB_33DD) begin
                failures++;
                $display("FAIL be_model[%0d] got=%h exp=11bb33dd", i, mdl_mem[i][2]);
            end
            checks++;
            if (obs_q[i].size() - obs_rd[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL be_count[%0d] got=%0d exp=%0d", i, obs_q[i].size() - obs_rd[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL be_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    task automatic test_rdw();
        drive_cycle(1'b0, 3'd0, 1'b1, 3'd3, 32'h0, 4'hF);
        drive_cycle(1'b1, 3'd3, 1'b1, 3'd3, 32'hFFFF_FFFF, 4'b0011);
        drive_cycle(1'b1, 3'd3, 1'b0, 3'd0, 32'h0, 4'h0);
        drive_cycle(1'b1, 3'd1, 1'b1, 3'd4, 32'h5A5A_5A5A, 4'hF);
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_q[i].size() - obs_rd[i] != 3) begin
                failures++;
                $display("FAIL rdw_count[%0d] got=%0d exp=3", i, obs_q[i].size() - obs_rd[i]);
            end else begin
                checks++;
                if (obs_q[i][obs_rd[i]].data !== ((i % 2 == 1) ? 32'h0000_FFFF : 32'h0)) begin
                    failures++;
                    $display("FAIL rdw_same[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i]].data,
                             (i % 2 == 1) ? 32'h0000_FFFF : 32'h0);
                end
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL rdw_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    task automatic test_out_of_range();
        drive_cycle(1'b0, 3'd0, 1'b1, 3'd7, $urandom, 4'hF);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_err[i] !== (ne(i) < 8)) begin
                failures++;
                $display("FAIL oob_werr_pulse[%0d] got=%b exp=%b", i, w_err[i], ne(i) < 8);
            end
        end
        step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (w_err[i] !== 1'b0) begin
                failures++;
                $display("FAIL oob_werr_clear[%0d] got=%b exp=0", i, w_err[i]);
            end
        end
        drive_cycle(1'b0, 3'd0, 1'b1, 3'd6, $urandom, 4'h0);
        for (int a = 0; a < 8; a++) drive_cycle(1'b1, 3'(a), 1'b0, 3'd0, 32'h0, 4'h0);
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (werr_cnt[i] != exp_werr[i]) begin
                failures++;
                $display("FAIL oob_werr_count[%0d] got=%0d exp=%0d", i, werr_cnt[i], exp_werr[i]);
            end
            checks++;
            if (obs_q[i].size() - obs_rd[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL oob_count[%0d] got=%0d exp=%0d", i, obs_q[i].size() - obs_rd[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL oob_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive_cycle(1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
                        $urandom, 4'($urandom));
        end
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (werr_cnt[i] != exp_werr[i]) begin
                failures++;
                $display("FAIL rand_werr_count[%0d] got=%0d exp=%0d", i, werr_cnt[i], exp_werr[i]);
            end
            checks++;
            if (obs_q[i].size() - obs_rd[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, obs_q[i].size() - obs_rd[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL rand_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    task automatic test_reset_mid();
        int r;
        for (int a = 0; a < 3; a++) drive_cycle(1'b0, 3'd0, 1'b1, 3'(a), 32'h8000_0000 | $urandom, 4'hF);
        for (int a = 0; a < 3; a++) drive_cycle(1'b1, 3'(a), 1'b0, 3'd0, 32'h0, 4'h0);
        rst_n = 1'b0;
        r = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            while (exp_q[i].size() > 0 && exp_q[i][exp_q[i].size() - 1].stamp >= r) void'(exp_q[i].pop_back());
        end
        step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (r_valid[i] !== 1'b0 || r_data[i] !== 32'h0 || ready[i] !== 1'b0) begin
                failures++;
                $display("FAIL midreset_outputs[%0d] got val=%b data=%h rdy=%b exp val=0 data=0 rdy=0",
                         i, r_valid[i], r_data[i], ready[i]);
            end
        end
        model_clear();
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (ready[i] !== (n >= ne(i))) begin
                    failures++;
                    $display("FAIL midreset_ready[%0d] n=%0d got=%b exp=%b", i, n, ready[i], n >= ne(i));
                end
            end
        end
        for (int a = 0; a < 3; a++) drive_cycle(1'b1, 3'(a), 1'b0, 3'd0, 32'h0, 4'h0);
        repeat (6) step();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_q[i].size() - obs_rd[i] != exp_q[i].size()) begin
                failures++;
                $display("FAIL midreset_count[%0d] got=%0d exp=%0d", i, obs_q[i].size() - obs_rd[i], exp_q[i].size());
            end
            for (int k = 0; k < exp_q[i].size() && obs_rd[i] + k < obs_q[i].size(); k++) begin
                checks++;
                if (obs_q[i][obs_rd[i] + k] !== exp_q[i][k]) begin
                    failures++;
                    $display("FAIL midreset_rsp[%0d] got=%h exp=%h", i, obs_q[i][obs_rd[i] + k], exp_q[i][k]);
                end
            end
            obs_rd[i] = obs_q[i].size();
            exp_q[i].delete();
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            obs_rd[i] = 0;
            exp_werr[i] = 0;
        end
        test_reset();
        test_clear();
        test_latency();
        test_byte_enable();
        test_rdw();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_pipelined.md
Name: mem_pipelined

Overview:
- Parametrised single-clock, one-read/one-write scratchpad memory for the systolic array operand and result buffers.
- Successor to the basic behavioural memory. Adds:
  - configurable read latency with a valid strobe
  - byte-enable writes
  - selectable read-during-write semantics
  - out-of-range detection for non-power-of-two depths
  - an optional hardware clear sequence after reset, with a ready indication

Parameters:
- NUM_ENTRIES, 64, number of words; any value >= 2, not required to be a power of two.
- WORD_SIZE, 32, bits per word.
- BYTE_WIDTH, 8, bits per byte lane; WORD_SIZE must be a multiple of BYTE_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to r_valid; legal range 1..4.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = read returns newly written (merged) data.
- CLEAR_ON_RESET, 1, 1 = zero every entry after reset before asserting ready; 0 = ready immediately.
- ADDR_WIDTH, $clog2(NUM_ENTRIES), address width (derived).
- NUM_BYTES, WORD_SIZE/BYTE_WIDTH, byte lanes per word (derived).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ready  output  1  high when requests are accepted.
- r_en  input  1  read request; accepted when r_en && ready.
- r_addr  input  ADDR_WIDTH  read word address.
- r_data  output  WORD_SIZE  read data; valid when r_valid.
- r_valid  output  1  one-cycle strobe per accepted read.
- r_err  output  1  qualifies r_valid: the read address was >= NUM_ENTRIES.
- w_en  input  1  write request; accepted when w_en && ready.
- w_addr  input  ADDR_WIDTH  write word address.
- w_data  input  WORD_SIZE  write data.
- w_be  input  NUM_BYTES  per-lane write enable; bit i covers w_data[i*BYTE_WIDTH +: BYTE_WIDTH].
- w_err  output  1  registered one-cycle pulse: an accepted write had w_addr >= NUM_ENTRIES.

Behaviour:
- Reset (rst_n low at an edge):
  - ready, r_valid, r_err, w_err = 0; r_data = 0.
  - Read pipeline flushed; no r_valid is ever produced for requests in flight at reset.
  - Clear counter = 0; FSM enters INIT if CLEAR_ON_RESET = 1, else RUN.
- FSM states:
  - INIT: ready = 0. Each cycle writes all-zero to entry clear_cnt, then clear_cnt++. After the cycle writing entry NUM_ENTRIES-1, go to RUN. First cycle with ready = 1 is exactly NUM_ENTRIES cycles after the first cycle with rst_n high.
  - RUN: ready = 1. Remains in RUN until reset.
- Requests while ready = 0 are ignored: no memory update, no r_valid, no errors.
- Reset asserted during INIT or RUN restarts the sequence from the reset rule; memory is cleared again when CLEAR_ON_RESET = 1.
- Reads:
  - Fully pipelined; one read accepted per cycle.
  - A read accepted at edge k gives r_valid = 1 with its data during the cycle after edge k+READ_LATENCY-1, i.e. READ_LATENCY registered stages.
  - Order is preserved.
  - r_data holds its last value while r_valid = 0.
- Writes:
  - A write accepted at edge k updates only the lanes with w_be[i] = 1, at edge k.
  - w_be = 0 is a legal no-op: no update and no w_err, even if the address is out of range.
- Out of range (addr >= NUM_ENTRIES, only possible when NUM_ENTRIES is not a power of two):
  - Write: discarded; w_err pulses for one cycle.
  - Read: produces r_valid with r_data = 0 and r_err = 1 at normal latency.
- Same-address read and write in one cycle (both accepted):
  - RDW_MODE 0: read returns the pre-write word.
  - RDW_MODE 1: read returns the pre-write word with the enabled lanes replaced by w_data.
  - Different addresses are independent.
- A read accepted one or more cycles after a write always observes that write.
- Storage is not reset by rst_n except through INIT. When CLEAR_ON_RESET = 0, contents are undefined until written.

Test Plan:
- Clear sequence: NUM_ENTRIES = 8, CLEAR_ON_RESET = 1. Deassert rst_n -> ready rises 8 cycles later. Stuck-high r_en/w_en during INIT -> no r_valid, no write. Then read all 8 addresses -> all return 0.
- Latency sweep: READ_LATENCY = 1..4. Write 0xA5A5_0000+addr to addr 0..7, then back-to-back reads 0..7 -> r_valid high for 8 consecutive cycles starting READ_LATENCY cycles after the first accept, with data in address order.
- Byte enables: write 0x11223344 with be = 4'b1111, then 0xAABBCCDD with be = 4'b0101 -> read returns 0x11BB33DD. A write with be = 0 leaves the word unchanged.
- Read-during-write: addr 3 holds 0x0; same-cycle read and write of 0xFFFF_FFFF with be = 4'b0011 -> RDW_MODE 0 returns 0x0, RDW_MODE 1 returns 0x0000_FFFF. A read of addr 3 one cycle later returns 0x0000_FFFF in both modes.
- Out of range: NUM_ENTRIES = 6. Write addr 7 -> w_err pulses one cycle and entries 0..5 are unchanged. Read addr 6 -> r_valid with r_err = 1 and r_data = 0. Read addr 5 -> r_err = 0.
- Reset mid-stream: READ_LATENCY = 3. Issue 3 reads, then assert rst_n low for 1 cycle -> no r_valid for them, r_data = 0, ready low for NUM_ENTRIES cycles, previously written data reads back as 0.
